// File: rtl/mem_filler.sv
// mem_filler: fills an inclusive address range [start_addr, end_addr] with a
// selectable pattern, one word per acknowledged write, on behalf of the
// boot/reset controller.
//
// Optional verify pass: define MEM_FILLER_VERIFY_EN to add the read-back
// ports (rd, rdata, rvalid, err_count, first_err_addr) and the VRD state.
// In the default build none of that logic or those ports exist.
//
// Patterns (k = word index from 0 at start_addr):
//   mode 0 : fill_value
//   mode 1 : fill_value + k (mod 2^DW)
//   mode 2 : fill_value ^ addr[DW-1:0]
//   mode 3 : same as mode 0
//
// The address compare against end_addr is an equality test, so a range that
// ends at the top of the address space stops there instead of wrapping.
// DW must not exceed AW.

module mem_filler #(
    parameter int AW = 25,
    parameter int DW = 8
`ifdef MEM_FILLER_VERIFY_EN
   ,parameter int CW = 16
`endif
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          ena,
    input  logic          trigger,
    input  logic          abort,
    input  logic [AW-1:0] start_addr,
    input  logic [AW-1:0] end_addr,
    input  logic [1:0]    mode,
    input  logic [DW-1:0] fill_value,
    output logic          erasing,
    output logic          done,
    output logic          aborted,
    output logic          range_err,
    output logic          wr,
    input  logic          ack,
    output logic [AW-1:0] addr,
    output logic [DW-1:0] data
`ifdef MEM_FILLER_VERIFY_EN
   ,output logic          rd,
    input  logic [DW-1:0] rdata,
    input  logic          rvalid,
    output logic [CW-1:0] err_count,
    output logic [AW-1:0] first_err_addr
`endif
);

    // state  | meaning
    // IDLE   | waiting for trigger
    // WRITE  | wr held high until each word is acked
    // FINISH | one cycle to emit done and drop erasing
    // VRD    | rd held high until rvalid, then compare (verify build only)
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WRITE  = 2'd1,
        S_FINISH = 2'd2,
        S_VRD    = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] end_q, end_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] data_q, data_d;
    logic [DW-1:0] k_q, k_d;
    logic [DW-1:0] fill_q, fill_d;
    logic [1:0]    mode_q, mode_d;
    logic          wr_q, wr_d;
    logic          erasing_q, erasing_d;
    logic          done_q, done_d;
    logic          aborted_q, aborted_d;
    logic          range_err_q, range_err_d;
    logic          at_end;
    logic          stop_abort;
    logic [AW-1:0] addr_nxt;
    logic [DW-1:0] k_nxt;
`ifdef MEM_FILLER_VERIFY_EN
    logic [AW-1:0] start_q, start_d;
    logic          rd_q, rd_d;
    logic [CW-1:0] err_cnt_q, err_cnt_d;
    logic [AW-1:0] first_err_q, first_err_d;
`endif

    function automatic logic [DW-1:0] pattern(input logic [1:0]    m,
                                              input logic [DW-1:0] f,
                                              input logic [DW-1:0] a_lo,
                                              input logic [DW-1:0] k);
        case (m)
            2'd1:    return f + k;
            2'd2:    return f ^ a_lo;
            default: return f;
        endcase
    endfunction

    assign at_end     = (addr_q == end_q);
    assign stop_abort = abort && !at_end;
    assign addr_nxt   = addr_q + 1'b1;
    assign k_nxt      = k_q + 1'b1;

    // State register; advances only on enabled edges.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else if (ena) begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (trigger) begin
                    state_d = (start_addr > end_addr) ? S_FINISH : S_WRITE;
                end
            end
            S_WRITE: begin
                if (ack && (at_end || abort)) begin
`ifdef MEM_FILLER_VERIFY_EN
                    state_d = stop_abort ? S_FINISH : S_VRD;
`else
                    state_d = S_FINISH;
`endif
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            S_VRD: begin
`ifdef MEM_FILLER_VERIFY_EN
                if (rvalid && (at_end || abort)) begin
                    state_d = S_FINISH;
                end
`else
                state_d = S_IDLE;
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output and datapath next values; done defaults low so it lasts one ena cycle.
    always_comb begin
        end_d       = end_q;
        addr_d      = addr_q;
        data_d      = data_q;
        k_d         = k_q;
        fill_d      = fill_q;
        mode_d      = mode_q;
        wr_d        = wr_q;
        erasing_d   = erasing_q;
        done_d      = 1'b0;
        aborted_d   = aborted_q;
        range_err_d = range_err_q;
`ifdef MEM_FILLER_VERIFY_EN
        start_d     = start_q;
        rd_d        = rd_q;
        err_cnt_d   = err_cnt_q;
        first_err_d = first_err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (trigger) begin
                    end_d       = end_addr;
                    mode_d      = mode;
                    fill_d      = fill_value;
                    aborted_d   = 1'b0;
                    range_err_d = 1'b0;
                    erasing_d   = 1'b1;
`ifdef MEM_FILLER_VERIFY_EN
                    start_d     = start_addr;
                    err_cnt_d   = '0;
                    first_err_d = '0;
`endif
                    if (start_addr > end_addr) begin
                        range_err_d = 1'b1;
                    end else begin
                        wr_d   = 1'b1;
                        addr_d = start_addr;
                        k_d    = '0;
                        data_d = pattern(mode, fill_value, start_addr[DW-1:0], '0);
                    end
                end
            end
            S_WRITE: begin
                if (ack) begin
                    if (at_end || abort) begin
                        wr_d      = 1'b0;
                        aborted_d = stop_abort;
`ifdef MEM_FILLER_VERIFY_EN
                        if (!stop_abort) begin
                            rd_d   = 1'b1;
                            addr_d = start_q;
                            k_d    = '0;
                            data_d = pattern(mode_q, fill_q, start_q[DW-1:0], '0);
                        end
`endif
                    end else begin
                        addr_d = addr_nxt;
                        k_d    = k_nxt;
                        data_d = pattern(mode_q, fill_q, addr_nxt[DW-1:0], k_nxt);
                    end
                end
            end
            S_FINISH: begin
                done_d    = 1'b1;
                erasing_d = 1'b0;
            end
            S_VRD: begin
`ifdef MEM_FILLER_VERIFY_EN
                // data_q holds the recomputed pattern for the word being read.
                if (rvalid) begin
                    if (rdata != data_q) begin
                        if (err_cnt_q == '0) begin
                            first_err_d = addr_q;
                        end
                        if (err_cnt_q != {CW{1'b1}}) begin
                            err_cnt_d = err_cnt_q + 1'b1;
                        end
                    end
                    if (at_end || abort) begin
                        rd_d      = 1'b0;
                        aborted_d = stop_abort;
                    end else begin
                        addr_d = addr_nxt;
                        k_d    = k_nxt;
                        data_d = pattern(mode_q, fill_q, addr_nxt[DW-1:0], k_nxt);
                    end
                end
`endif
            end
            default: ;
        endcase
    end

    // Datapath and status registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            end_q       <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            k_q         <= '0;
            fill_q      <= '0;
            mode_q      <= '0;
            wr_q        <= 1'b0;
            erasing_q   <= 1'b0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
            range_err_q <= 1'b0;
`ifdef MEM_FILLER_VERIFY_EN
            start_q     <= '0;
            rd_q        <= 1'b0;
            err_cnt_q   <= '0;
            first_err_q <= '0;
`endif
        end else if (ena) begin
            end_q       <= end_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            k_q         <= k_d;
            fill_q      <= fill_d;
            mode_q      <= mode_d;
            wr_q        <= wr_d;
            erasing_q   <= erasing_d;
            done_q      <= done_d;
            aborted_q   <= aborted_d;
            range_err_q <= range_err_d;
`ifdef MEM_FILLER_VERIFY_EN
            start_q     <= start_d;
            rd_q        <= rd_d;
            err_cnt_q   <= err_cnt_d;
            first_err_q <= first_err_d;
`endif
        end
    end

    assign erasing   = erasing_q;
    assign done      = done_q;
    assign aborted   = aborted_q;
    assign range_err = range_err_q;
    assign wr        = wr_q;
    assign addr      = addr_q;
    assign data      = data_q;
`ifdef MEM_FILLER_VERIFY_EN
    assign rd             = rd_q;
    assign err_count      = err_cnt_q;
    assign first_err_addr = first_err_q;
`endif

endmodule
